// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Two-stage pipelined LEGv8 immediate decoder sitting between fetch and
//   the execute-stage operand mux.
//   S1 registers the instruction and its classified format (I/D/B/CB/IM/NONE).
//   S2 extracts, extends and shifts the immediate and registers it to the outputs.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instr        fetched 32-bit instruction
//   instr_valid  instr is a real instruction this cycle
//   stall        hold both stages
//   flush        invalidate both stages (wins over stall)
//   imm_out      64-bit extended immediate
//   imm_kind     format code: 0=NONE 1=I 2=D 3=B 4=CB 5=IM
//   imm_valid    imm_out/imm_kind belong to a live instruction
module imm_decode_stage #(
  parameter int unsigned BR_SCALE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [63:0] imm_out,
  output logic [2:0]  imm_kind,
  output logic        imm_valid
);

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_I    = 3'd1,
    KIND_D    = 3'd2,
    KIND_B    = 3'd3,
    KIND_CB   = 3'd4,
    KIND_IM   = 3'd5
  } kind_e;

  // Stage 1 state. Only instr[25:0] is needed after classification, so the
  // opcode bits are not carried into S1.
  logic [25:0] s1_field_q;
  logic        s1_valid_q;
  kind_e       s1_kind_q;
  kind_e       kind_d;

  // Stage 2 (output) state
  logic [63:0] imm_q, imm_d;
  kind_e       imm_kind_q;
  logic        imm_valid_q;

  // Opcode classification, priority B > CB > IM > D > I.
  always_comb begin
    kind_d = KIND_NONE;
    if (instr[31:26] inside {6'b000101, 6'b100101})
      kind_d = KIND_B;
    else if (instr[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100})
      kind_d = KIND_CB;
    else if (instr[31:23] inside {9'b110100101, 9'b111100101})
      kind_d = KIND_IM;
    else if (instr[31:21] inside {11'b11111000010, 11'b11111000000})
      kind_d = KIND_D;
    else if (instr[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                  10'b1111000100, 10'b1001001000})
      kind_d = KIND_I;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_field_q <= '0;
      s1_valid_q <= 1'b0;
      s1_kind_q  <= KIND_NONE;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= KIND_NONE;
    end else if (!stall) begin
      s1_field_q <= instr[25:0];
      s1_valid_q <= instr_valid;
      s1_kind_q  <= instr_valid ? kind_d : KIND_NONE;
    end
  end

  // Immediate extraction; extension first, then shift within 64 bits.
  always_comb begin
    imm_d = '0;
    if (s1_valid_q) begin
      case (s1_kind_q)
        KIND_I:  imm_d = {52'b0, s1_field_q[21:10]};
        KIND_D:  imm_d = {{55{s1_field_q[20]}}, s1_field_q[20:12]};
        KIND_B:  imm_d = {{38{s1_field_q[25]}}, s1_field_q[25:0]} << BR_SCALE;
        KIND_CB: imm_d = {{45{s1_field_q[23]}}, s1_field_q[23:5]} << BR_SCALE;
        KIND_IM: imm_d = {48'b0, s1_field_q[20:5]} << {s1_field_q[22:21], 4'b0000};
        default: imm_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_q       <= '0;
      imm_kind_q  <= KIND_NONE;
      imm_valid_q <= 1'b0;
    end else if (flush) begin
      imm_q       <= '0;
      imm_kind_q  <= KIND_NONE;
      imm_valid_q <= 1'b0;
    end else if (!stall) begin
      imm_q       <= imm_d;
      imm_kind_q  <= s1_kind_q;
      imm_valid_q <= s1_valid_q;
    end
  end

  assign imm_out   = imm_q;
  assign imm_kind  = imm_kind_q;
  assign imm_valid = imm_valid_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
//   Directed and randomized stimulus for imm_decode_stage, checked against a
//   behavioural decode/pipeline model kept in this bench.
module tb_imm_decode_stage;

  localparam int unsigned BR = 2;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        flush;
  logic [63:0] imm_out;
  logic [2:0]  imm_kind;
  logic        imm_valid;

  imm_decode_stage #(.BR_SCALE(BR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .flush       (flush),
    .imm_out     (imm_out),
    .imm_kind    (imm_kind),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference decode: field value taken as a number, sign handled by
  // subtracting 2^width, scaling done by multiplication (mod 2^64).
  function automatic void ref_decode(input logic [31:0] ins,
                                     output logic [2:0] k, output logic [63:0] v);
    logic [63:0] f;
    k = 3'd0;
    v = 64'd0;
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      k = 3'd3;
      f = 64'(ins[25:0]);
      if (f >= (64'd1 << 25)) f = f - (64'd1 << 26);
      v = f * (64'd1 << BR);
    end else if (ins[31:24] == 8'b10110100 || ins[31:24] == 8'b10110101 ||
                 ins[31:24] == 8'b01010100) begin
      k = 3'd4;
      f = 64'(ins[23:5]);
      if (f >= (64'd1 << 18)) f = f - (64'd1 << 19);
      v = f * (64'd1 << BR);
    end else if (ins[31:23] == 9'b110100101 || ins[31:23] == 9'b111100101) begin
      k = 3'd5;
      v = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
    end else if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      k = 3'd2;
      f = 64'(ins[20:12]);
      if (f >= 64'd256) f = f - 64'd512;
      v = f;
    end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1011000100 ||
                 ins[31:22] == 10'b1101000100 || ins[31:22] == 10'b1111000100 ||
                 ins[31:22] == 10'b1001001000) begin
      k = 3'd1;
      v = 64'(ins[21:10]);
    end
  endfunction

  // Model pipeline: instruction waiting in slot 1, and visible output.
  logic        m1_v;
  logic [31:0] m1_ins;
  logic        mo_v;
  logic [2:0]  mo_k;
  logic [63:0] mo_imm;

  task automatic model_reset();
    m1_v = 1'b0; m1_ins = '0; mo_v = 1'b0; mo_k = '0; mo_imm = '0;
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic st, input logic fl);
    logic [2:0]  k;
    logic [63:0] val;
    instr = i; instr_valid = v; stall = st; flush = fl;
    @(posedge clk);
    if (fl) begin
      m1_v = 1'b0; mo_v = 1'b0; mo_k = '0; mo_imm = '0;
    end else if (!st) begin
      ref_decode(m1_ins, k, val);
      mo_v   = m1_v;
      mo_k   = m1_v ? k : 3'd0;
      mo_imm = m1_v ? val : 64'd0;
      m1_v   = v;
      m1_ins = i;
    end
    #1;
    chk("valid", 64'(imm_valid), 64'(mo_v));
    chk("kind",  64'(imm_kind),  64'(mo_k));
    chk("imm",   imm_out,        mo_imm);
  endtask

  function automatic logic [31:0] addi(input logic [11:0] f);
    return {10'b1001000100, f, 5'd1, 5'd2};
  endfunction

  // Random instruction biased toward each format.
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      1: case ($urandom_range(0, 2))
           0: r[31:24] = 8'b10110100;
           1: r[31:24] = 8'b10110101;
           default: r[31:24] = 8'b01010100;
         endcase
      2: r[31:23] = ($urandom_range(0, 1) != 0) ? 9'b110100101 : 9'b111100101;
      3: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
      4: case ($urandom_range(0, 4))
           0: r[31:22] = 10'b1001000100;
           1: r[31:22] = 10'b1011000100;
           2: r[31:22] = 10'b1101000100;
           3: r[31:22] = 10'b1111000100;
           default: r[31:22] = 10'b1001001000;
         endcase
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [2:0]  kind;
  } dir_t;

  dir_t dir[8];

  initial begin
    dir[0] = '{addi(12'h005), 64'h0000000000000005, 3'd1};
    dir[1] = '{addi(12'hFFF), 64'h0000000000000FFF, 3'd1};
    dir[2] = '{{11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd4}, 64'hFFFFFFFFFFFFFFF8, 3'd2};
    dir[3] = '{{11'b11111000000, 9'h0FF, 2'b00, 5'd3, 5'd4}, 64'h00000000000000FF, 3'd2};
    dir[4] = '{{6'b000101, 26'h3FFFFFF}, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    dir[5] = '{{8'b10110100, 19'h00010, 5'd0}, 64'h0000000000000040, 3'd4};
    dir[6] = '{{9'b110100101, 2'd2, 16'hABCD, 5'd0}, 64'h0000ABCD00000000, 3'd5};
    dir[7] = '{{9'b111100101, 2'd3, 16'hFFFF, 5'd0}, 64'hFFFF000000000000, 3'd5};

    instr = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("rst_imm",   imm_out, 64'd0);
    chk("rst_kind",  64'(imm_kind), 64'd0);
    chk("rst_valid", 64'(imm_valid), 64'd0);
    #6 reset_n = 1'b1;

    // Directed stream: each result shows one step after the next is sampled.
    for (int i = 0; i < 8; i++) begin
      step(dir[i].ins, 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        chk("dir_imm",  imm_out, dir[i-1].imm);
        chk("dir_kind", 64'(imm_kind), 64'(dir[i-1].kind));
      end
    end
    step('0, 1'b0, 1'b0, 1'b0);
    chk("dir_imm_last", imm_out, dir[7].imm);
    step('0, 1'b0, 1'b0, 1'b0);
    chk("bubble_imm", imm_out, 64'd0);

    // Stream with stall after #2 is sampled, then flush with a new instruction.
    step(addi(12'd1), 1'b1, 1'b0, 1'b0);
    step(addi(12'd2), 1'b1, 1'b0, 1'b0);
    chk("s_out1", imm_out, 64'd1);
    step(addi(12'h7AA), 1'b1, 1'b1, 1'b0);
    chk("stall1", imm_out, 64'd1);
    step(addi(12'h7BB), 1'b1, 1'b1, 1'b0);
    chk("stall2", imm_out, 64'd1);
    step(addi(12'd3), 1'b1, 1'b0, 1'b0);
    chk("s_out2", imm_out, 64'd2);
    step('0, 1'b0, 1'b0, 1'b0);
    chk("s_out3", imm_out, 64'd3);
    step(addi(12'd4), 1'b1, 1'b1, 1'b1);
    chk("flush_valid", 64'(imm_valid), 64'd0);
    chk("flush_imm", imm_out, 64'd0);
    step('0, 1'b0, 1'b0, 1'b0);
    chk("flushed_gone", imm_out, 64'd0);

    // R-type ADD: live but no immediate.
    step({11'b10001011000, 5'd1, 6'd0, 5'd2, 5'd3}, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    chk("rtype_valid", 64'(imm_valid), 64'd1);
    chk("rtype_kind", 64'(imm_kind), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(rand_instr(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 6));
    end

    // Reset between edges with data in flight.
    step(dir[4].ins, 1'b1, 1'b0, 1'b0);
    step(dir[6].ins, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_imm",   imm_out, 64'd0);
    chk("mid_rst_kind",  64'(imm_kind), 64'd0);
    chk("mid_rst_valid", 64'(imm_valid), 64'd0);
    #2 reset_n = 1'b1;
    step('0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_imm", imm_out, 64'd0);
    step(dir[5].ins, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_cb", imm_out, 64'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
